prog_counter: RTL
=================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter: N, default 8, counter width in bits (N >= 2).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  count enable; low holds q, state and tone; tc forced low.
REQ-005 Port: load  input  1  synchronous load of load_val into q.
REQ-006 Port: load_val  input  N  value loaded when load is high.
REQ-007 Port: limit  input  N  terminal value for the modulo and one-shot modes.
REQ-008 Port: up  input  1  direction: 1 increments, 0 decrements.
REQ-009 Port: mode  input  2  00 free-run, 01 modulo, 10 one-shot, 11 hold (reserved).
REQ-010 Port: start  input  1  one-shot trigger, sampled only in IDLE or DONE.
REQ-011 Port: q  output  N  registered count.
REQ-012 Port: tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-013 Port: busy  output  1  high while the one-shot FSM is in RUN.

Function
REQ-014 Priority, highest first, SHALL be: reset, load, mode/FSM action gated by en.
REQ-015 Load SHALL set q to load_val on the next edge, clear tc and leave FSM state and tone unchanged; load with start SHALL ignore start.
REQ-016 Free-run SHALL step q by 1 modulo 2^N: up wraps 2^N-1 to 0, down wraps 0 to 2^N-1; tc SHALL be high in the cycle after each wrap edge.
REQ-017 Modulo, up SHALL count 0..limit; from q >= limit the next enabled edge SHALL set q=0 and raise tc.
REQ-018 Modulo, down SHALL count limit..0; from q == 0 the next enabled edge SHALL set q=limit and raise tc; from q > limit it SHALL set q=limit without tc.
REQ-019 Modulo with limit=0 SHALL hold q=0 and raise tc on every enabled cycle.
REQ-020 One-shot FSM states SHALL be IDLE, RUN and DONE; busy=1 only in RUN.
REQ-021 In IDLE or DONE, en&start SHALL enter RUN with q=0 (up) or q=limit (down).
REQ-022 In RUN, each enabled edge SHALL step q toward the terminal value (limit if up, 0 if down); once q equals it, the next enabled edge SHALL enter DONE, raise tc and hold q.
REQ-023 start in RUN SHALL be ignored; limit=0 (up) or down-from-0 SHALL complete one enabled edge after entry.
REQ-024 Any mode other than 10 SHALL force the FSM to IDLE on the next edge; busy SHALL drop.
REQ-025 Mode 11 SHALL hold q with tc=0.
REQ-026 A direction change mid-count SHALL take effect on the next enabled edge, with no other side effect.

Reset
REQ-027 Reset SHALL asynchronously force q=0, tc=0, busy=0, FSM=IDLE and tone=0 (when present).
REQ-028 Reset asserted mid one-shot SHALL abort the run; after release the counter waits for a new start.

Configuration
REQ-029 Macro TOGGLE_OUT_EN, when defined, SHALL add output port tone (1 bit), inverted on every edge that raises tc and unaffected by load, giving a square wave of period 2*(limit+1) cycles in modulo mode.
REQ-030 Without TOGGLE_OUT_EN, port tone and its register SHALL be absent, with all other behaviour identical.

Verification
REQ-031 N=4, mode 00, up=1, en=1 for 20 cycles from reset -> q runs 0..15,0..3; tc high exactly once, in the cycle q=0 after the wrap.
REQ-032 N=4, mode 01, limit=5, up=0, en=1 -> q sequence 0,5,4,3,2,1,0,5; tc high in each cycle q=5 after a wrap; with TOGGLE_OUT_EN, tone period 12 cycles.
REQ-033 N=4, mode 10, limit=3, up=1, start pulse -> busy high 4 cycles, q 0,1,2,3 then held at 3; tc one pulse on entering DONE; a start during RUN has no effect.
REQ-034 N=4, mode 01, q counting, load=1 with load_val=9 and limit=5, up=1 -> q=9, next enabled edge q=0 with tc=1.
REQ-035 Reset asserted asynchronously mid one-shot at q=2 -> q=0, busy=0, tc=0 immediately, without waiting for a clock edge; no counting until a new start.
REQ-036 en=0 for 5 cycles during modulo count at q=4 -> q stays 4, tc=0; counting resumes at 5.

Source files
------------

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
//   Programmable N-bit up/down counter with free-run, modulo, one-shot and
//   hold modes.  q, tc and busy all come straight from registers.
//
// Optional feature macro: TOGGLE_OUT_EN
//   When this macro is defined, the block gets an extra output, tone.  tone
//   flips on every edge that drives tc high.  In the default build the port
//   and its register do not exist.
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   reset     in   asynchronous active-high reset
//   en        in   count enable; when low, q/state/tone hold and tc goes low
//   load      in   synchronous load of load_val into q; overrides counting
//   load_val  in   N-bit value to load
//   limit     in   N-bit terminal value for the modulo and one-shot modes
//   up        in   1 = count up, 0 = count down
//   mode      in   00 free-run, 01 modulo, 10 one-shot, 11 hold
//   start     in   one-shot trigger; only accepted in IDLE or DONE
//   q         out  count value
//   tc        out  terminal-count pulse
//   busy      out  high while the one-shot is in RUN
//   tone      out  (TOGGLE_OUT_EN only) square wave, toggled by each tc
// ---------------------------------------------------------------------------
module prog_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] limit,
  input  logic         up,
  input  logic [1:0]   mode,
  input  logic         start,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         busy
`ifdef TOGGLE_OUT_EN
  ,
  output logic         tone
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] M_FREE = 2'b00;
  localparam logic [1:0] M_MOD  = 2'b01;
  localparam logic [1:0] M_ONE  = 2'b10;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ALL1 = '1;

  logic [N-1:0] r_q;
  logic         r_tc;
  state_t       r_state;

  logic [N-1:0] w_q_next;
  logic         w_tc_next;
  state_t       w_state_next;
  logic [N-1:0] w_term;

  // The one-shot stops at limit when counting up and at 0 when counting down.
  assign w_term = up ? limit : ZERO;

  always_comb begin
    w_q_next     = r_q;
    w_tc_next    = 1'b0;
    w_state_next = r_state;

    if (load) begin
      // A load only replaces q.  It does not change the FSM state, and any
      // start that arrives with it is ignored.
      w_q_next = load_val;
    end else begin
      // Leaving one-shot mode puts the FSM back in IDLE.  This happens
      // whether or not en is high.
      if (mode != M_ONE)
        w_state_next = S_IDLE;

      if (en) begin
        case (mode)
          M_FREE: begin
            if (up) begin
              w_q_next  = r_q + ONE;
              w_tc_next = (r_q == ALL1);
            end else begin
              w_q_next  = r_q - ONE;
              w_tc_next = (r_q == ZERO);
            end
          end

          M_MOD: begin
            if (up) begin
              // Use >= so that a q loaded above limit wraps to 0 on the next
              // edge.
              if (r_q >= limit) begin
                w_q_next  = ZERO;
                w_tc_next = 1'b1;
              end else begin
                w_q_next  = r_q + ONE;
              end
            end else begin
              if (r_q == ZERO) begin
                w_q_next  = limit;
                w_tc_next = 1'b1;
              end else if (r_q > limit) begin
                // Counting down from above limit: jump to limit without
                // raising tc.
                w_q_next  = limit;
              end else begin
                w_q_next  = r_q - ONE;
              end
            end
          end

          M_ONE: begin
            case (r_state)
              S_RUN: begin
                if (r_q == w_term) begin
                  w_state_next = S_DONE;
                  w_tc_next    = 1'b1;
                end else begin
                  w_q_next = up ? (r_q + ONE) : (r_q - ONE);
                end
              end
              default: begin
                if (start) begin
                  w_state_next = S_RUN;
                  w_q_next     = up ? ZERO : limit;
                end
              end
            endcase
          end

          default: begin
            // Mode 11 holds q, and tc stays low (its default).
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      r_tc    <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      r_q     <= w_q_next;
      r_tc    <= w_tc_next;
      r_state <= w_state_next;
    end
  end

`ifdef TOGGLE_OUT_EN
  logic r_tone;

  // w_tc_next is never set during a load, so a load cannot toggle tone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_tone <= 1'b0;
    else if (w_tc_next)
      r_tone <= ~r_tone;
  end

  assign tone = r_tone;
`endif

  assign q    = r_q;
  assign tc   = r_tc;
  assign busy = (r_state == S_RUN);

endmodule
